// File: rtl/mem_arbiter.sv
// mem_arbiter: merges I-cache and D-cache 128-bit line requests onto one
// shared memory port. A request is sampled only in IDLE, latched at the
// grant edge, replayed to memory from the latched copy, and the memory's
// one-cycle ready is steered back only to the granted cache.
//
// Build option: define MEM_ARB_DCACHE_PRIORITY_EN to make the D-cache win
// every tie (fixed priority). Left undefined, ties go round-robin on a
// last-grant flop that starts at D so the I-cache wins the first tie.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    // I-cache port
    input  logic              ic_mem_read,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    output logic [LINE_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    // D-cache port
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [LINE_W-1:0] dc_mem_wdata,
    output logic [LINE_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    // shared memory port
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // status
    output logic              grant_id,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // One latched memory transaction; id 0 = I-cache, 1 = D-cache.
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic              id;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    state_t state_q;
    req_t   req_q;
    req_t   req_d;
    logic   ic_req;
    logic   dc_req;
    logic   win_dc;

`ifndef MEM_ARB_DCACHE_PRIORITY_EN
    logic   last_grant_q;
`endif

    assign ic_req = ic_mem_read;
    assign dc_req = dc_mem_read | dc_mem_write;

    // Pick the winner among the currently asserted requests.
    always_comb begin
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
        // D-cache wins whenever it asks.
        win_dc = dc_req;
`else
        // Single requester wins; on a tie the port not granted last wins.
        win_dc = dc_req & (~ic_req | ~last_grant_q);
`endif
    end

    // Build the transaction to latch from the winning port.
    // A D-cache request with both read and write high is a write.
    always_comb begin
        req_d       = '0;
        req_d.id    = win_dc;
        req_d.wr    = win_dc & dc_mem_write;
        req_d.rd    = ~(win_dc & dc_mem_write);
        req_d.addr  = win_dc ? dc_mem_addr : ic_mem_addr;
        req_d.wdata = win_dc ? dc_mem_wdata : '0;
    end

    // Grant FSM: latch in IDLE, hold through SERVE until memory completes.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
`ifndef MEM_ARB_DCACHE_PRIORITY_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (ic_req | dc_req) begin
                        state_q      <= SERVE;
                        req_q        <= req_d;
`ifndef MEM_ARB_DCACHE_PRIORITY_EN
                        last_grant_q <= win_dc;
`endif
                    end
                end
                SERVE: begin
                    // Requester changes are ignored; only memory ends the beat.
                    if (mem_ready) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy     = (state_q == SERVE);
    assign grant_id = req_q.id;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

    // Strobes drop in the completion cycle so memory sees no second request.
    assign mem_read  = busy & req_q.rd & ~mem_ready;
    assign mem_write = busy & req_q.wr & ~mem_ready;

    // Ready goes only to the granted cache; a reset edge swallows it.
    assign ic_mem_ready = proc_reset_n & busy & mem_ready & ~req_q.id;
    assign dc_mem_ready = proc_reset_n & busy & mem_ready &  req_q.id;

    // Read data is broadcast; ready alone tells a cache the data is its own.
    assign ic_mem_rdata = mem_rdata;
    assign dc_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model with a
// per-cycle compare, plus directed sequences with literal expectations.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          proc_reset_n = 1'b0;
    logic          ic_mem_read = 1'b0;
    logic [AW-1:0] ic_mem_addr = '0;
    logic [LW-1:0] ic_mem_rdata;
    logic          ic_mem_ready;
    logic          dc_mem_read = 1'b0;
    logic          dc_mem_write = 1'b0;
    logic [AW-1:0] dc_mem_addr = '0;
    logic [LW-1:0] dc_mem_wdata = '0;
    logic [LW-1:0] dc_mem_rdata;
    logic          dc_mem_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_ready = 1'b0;
    logic          grant_id;
    logic          busy;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .proc_reset_n(proc_reset_n),
        .ic_mem_read(ic_mem_read), .ic_mem_addr(ic_mem_addr),
        .ic_mem_rdata(ic_mem_rdata), .ic_mem_ready(ic_mem_ready),
        .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
        .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
        .dc_mem_rdata(dc_mem_rdata), .dc_mem_ready(dc_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- memory responder ----------------
    logic [LW-1:0] rd_val = '0;
    int            lat = 3;
    int            cnt = 0;
    bit            spur_en = 1'b0;
    assign mem_rdata = rd_val;

    // Ready comes 'lat' strobe cycles after the strobe first appears.
    initial forever begin
        @(posedge clk); #1;
        if (spur_en) mem_ready = 1'b1;
        else if (mem_ready) begin mem_ready = 1'b0; cnt = 0; end
        else if (!busy) cnt = 0;
        else if (mem_read || mem_write) begin
            if (cnt == lat) mem_ready = 1'b1;
            else cnt++;
        end
    end

    // ---------------- transaction model ----------------
    bit            m_on = 1'b0;
    bit            m_busy = 1'b0;
    bit            m_grant = 1'b0;
    bit            m_wr = 1'b0;
    bit            m_last = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0;

    initial forever begin
        @(posedge clk);
        if (!proc_reset_n) begin
            m_on = 1'b1; m_busy = 1'b0; m_last = 1'b1;
        end else if (m_busy) begin
            if (mem_ready) m_busy = 1'b0;
        end else if (ic_mem_read || dc_mem_read || dc_mem_write) begin
            bit i_rq, d_rq, who;
            i_rq = ic_mem_read;
            d_rq = dc_mem_read || dc_mem_write;
            if (i_rq && d_rq) begin
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
                who = 1'b1;
`else
                who = !m_last;   // the other port than last time
`endif
            end else who = d_rq;
            m_busy  = 1'b1;
            m_grant = who;
            m_last  = who;
            m_wr    = who && dc_mem_write;
            m_addr  = who ? dc_mem_addr : ic_mem_addr;
            m_wdata = dc_mem_wdata;
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (m_on) begin
            chk("busy", busy, m_busy);
            chk("mem_read", mem_read, m_busy && !m_wr && !mem_ready);
            chk("mem_write", mem_write, m_busy && m_wr && !mem_ready);
            chk("ic_ready", ic_mem_ready, proc_reset_n && m_busy && mem_ready && !m_grant);
            chk("dc_ready", dc_mem_ready, proc_reset_n && m_busy && mem_ready && m_grant);
            chk("ic_rdata", ic_mem_rdata, mem_rdata);
            chk("dc_rdata", dc_mem_rdata, mem_rdata);
            if (m_busy) begin
                chk("grant_id", grant_id, m_grant);
                chk("mem_addr", mem_addr, m_addr);
                if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
            end
        end
    end

    // Log of transaction starts: {grant, write, addr}.
    logic [AW+1:0] logq[$];
    bit            bprev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (busy && !bprev) logq.push_back({grant_id, mem_write, mem_addr});
        bprev = busy;
    end

    // ---------------- cache drivers ----------------
    typedef struct { logic wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; } dreq_t;
    logic [AW-1:0] ic_q[$];
    dreq_t         dc_q[$];

    task automatic drive_heads(input int ic_wait);
        ic_mem_read  = (ic_q.size() > 0) && (ic_wait == 0);
        ic_mem_addr  = (ic_q.size() > 0) ? ic_q[0] : '0;
        dc_mem_read  = (dc_q.size() > 0) && !dc_q[0].wr;
        dc_mem_write = (dc_q.size() > 0) && dc_q[0].wr;
        dc_mem_addr  = (dc_q.size() > 0) ? dc_q[0].addr : '0;
        dc_mem_wdata = (dc_q.size() > 0) ? dc_q[0].wdata : '0;
    endtask

    // Each cache holds its head request until it sees ready, then moves on.
    task automatic run_seq(input int ic_dly);
        int  n, w;
        bit  ir, dr;
        n = 0; w = ic_dly;
        logq.delete();
        @(posedge clk); #1;
        drive_heads(w);
        while ((ic_q.size() > 0 || dc_q.size() > 0) && n < 300) begin
            @(negedge clk);
            ir = ic_mem_ready; dr = dc_mem_ready;
            @(posedge clk); #1;
            n++;
            if (ir && ic_q.size() > 0) void'(ic_q.pop_front());
            if (dr && dc_q.size() > 0) void'(dc_q.pop_front());
            if (w > 0) w--;
            drive_heads(w);
        end
        chk("seq_done", (n < 300), 1'b1);
    endtask

    task automatic wait_rdy(input bit d, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(d ? dc_mem_ready : ic_mem_ready) && n < 50);
        chk(nm, d ? dc_mem_ready : ic_mem_ready, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; proc_reset_n = 1'b0;
        @(posedge clk); #1; proc_reset_n = 1'b1;
    endtask

    task automatic chk_log(input string nm, input logic [AW+1:0] e0,
                           input logic [AW+1:0] e1, input logic [AW+1:0] e2, input int n);
        logic [AW+1:0] ex[3];
        ex[0] = e0; ex[1] = e1; ex[2] = e2;
        chk({nm, "_len"}, logq.size(), n);
        for (int k = 0; k < n && k < logq.size(); k++) chk(nm, logq[k], ex[k]);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1 proc_reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_grant", grant_id, 1'b0);
        chk("rst_strobes", {mem_read, mem_write, ic_mem_ready, dc_mem_ready}, 4'b0);

        // Single I-cache read: 3 strobe cycles, then ready with data.
        lat = 3; rd_val = {8{16'hAAAA}};
        @(posedge clk); #1; ic_mem_read = 1'b1; ic_mem_addr = 28'h0000010;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t1_mem_read", mem_read, 1'b1);
            chk("t1_mem_addr", mem_addr, 28'h0000010);
            chk("t1_no_ready", ic_mem_ready, 1'b0);
        end
        @(negedge clk);
        chk("t1_ic_ready", ic_mem_ready, 1'b1);
        chk("t1_rdata", ic_mem_rdata, {8{16'hAAAA}});
        chk("t1_strobe_drop", mem_read, 1'b0);
        @(posedge clk); #1; ic_mem_read = 1'b0;
        @(negedge clk);
        chk("t1_idle", busy, 1'b0);

        // Tie from reset: I first, then D.
        do_reset(); rd_val = {8{16'h5555}}; lat = 2;
        ic_q = '{28'h10};
        dc_q = '{'{1'b0, 28'h20, '0}};
        run_seq(0);
        chk_log("t2_order", {2'b00, 28'h10}, {2'b10, 28'h20}, '0, 2);

        // D writeback then allocate with I pending throughout.
        do_reset(); lat = 3;
        ic_q = '{28'h50};
        dc_q = '{'{1'b1, 28'h30, {8{16'h1234}}}, '{1'b0, 28'h40, '0}};
        run_seq(1);
        chk_log("t3_order", {2'b11, 28'h30}, {2'b00, 28'h50}, {2'b10, 28'h40}, 3);

        // Reset two cycles into a D write; the held request is re-served.
        lat = 3;
        @(posedge clk); #1;
        dc_mem_write = 1'b1; dc_mem_addr = 28'h60; dc_mem_wdata = {4{32'hDEADBEEF}};
        @(posedge clk);
        @(posedge clk); #1; proc_reset_n = 1'b0;
        @(posedge clk); #1; proc_reset_n = 1'b1;
        @(negedge clk);
        chk("t4_mem_write", mem_write, 1'b0);
        chk("t4_busy", busy, 1'b0);
        chk("t4_dc_ready", dc_mem_ready, 1'b0);
        chk("t4_mem_addr", mem_addr, '0);
        wait_rdy(1'b1, "t4_reserve");
        @(posedge clk); #1; dc_mem_write = 1'b0;

        // Reset coinciding with mem_ready: no ready forwarded.
        lat = 1;
        @(posedge clk); #1;
        dc_mem_write = 1'b1; dc_mem_addr = 28'hA0; dc_mem_wdata = {4{32'h0BADF00D}};
        @(posedge clk);
        @(posedge clk); #1; proc_reset_n = 1'b0;
        @(negedge clk);
        chk("t4b_mem_ready", mem_ready, 1'b1);
        chk("t4b_dc_ready", dc_mem_ready, 1'b0);
        @(posedge clk); #1; proc_reset_n = 1'b1;
        @(negedge clk);
        chk("t4b_busy", busy, 1'b0);
        wait_rdy(1'b1, "t4b_reserve");
        @(posedge clk); #1; dc_mem_write = 1'b0;

        // Spurious mem_ready in IDLE.
        @(posedge clk); #1; spur_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t5_ready", {ic_mem_ready, dc_mem_ready}, 2'b00);
            chk("t5_busy", busy, 1'b0);
        end
        @(posedge clk); #1; spur_en = 1'b0;
        @(negedge clk);
        chk("t5_stay_idle", busy, 1'b0);

        // D read and write together is a write.
        lat = 2;
        @(posedge clk); #1;
        dc_mem_read = 1'b1; dc_mem_write = 1'b1;
        dc_mem_addr = 28'hB0; dc_mem_wdata = {2{64'h0123456789ABCDEF}};
        @(posedge clk);
        @(negedge clk);
        chk("t6_write", {mem_write, mem_read}, 2'b10);
        chk("t6_wdata", mem_wdata, {2{64'h0123456789ABCDEF}});
        wait_rdy(1'b1, "t6_ready");
        @(posedge clk); #1; dc_mem_read = 1'b0; dc_mem_write = 1'b0;

        // Repeated ties: D keeps asking back-to-back while I waits.
        do_reset(); lat = 1;
        ic_q = '{28'h90};
        dc_q = '{'{1'b0, 28'h70, '0}, '{1'b0, 28'h80, '0}};
        run_seq(0);
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
        chk_log("t7_order", {2'b10, 28'h70}, {2'b10, 28'h80}, {2'b00, 28'h90}, 3);
`else
        chk_log("t7_order", {2'b00, 28'h90}, {2'b10, 28'h70}, {2'b10, 28'h80}, 3);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port line-memory arbiter that sits directly downstream of the instruction cache and the data cache.
- Merges their 128-bit line requests onto the single shared memory port.
- Uses the same request/ready handshake the caches already drive: the cache holds read/write plus address until it sees a one-cycle ready.
- Latches the granted request, replays it to memory, and steers ready back only to the granted cache.

Parameters:
- ADDR_W, 28, line address width (word address bits [29:2]).
- LINE_W, 128, cache line width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- proc_reset_n  in  1  synchronous reset, active-low.
- ic_mem_read  in  1  I-cache line read request.
- ic_mem_addr  in  ADDR_W  I-cache line address.
- ic_mem_rdata  out  LINE_W  read data to I-cache.
- ic_mem_ready  out  1  completion pulse to I-cache.
- dc_mem_read  in  1  D-cache line read request.
- dc_mem_write  in  1  D-cache line write (writeback) request.
- dc_mem_addr  in  ADDR_W  D-cache line address.
- dc_mem_wdata  in  LINE_W  D-cache writeback data.
- dc_mem_rdata  out  LINE_W  read data to D-cache.
- dc_mem_ready  out  1  completion pulse to D-cache.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion pulse, one cycle.
- grant_id  out  1  0 = I-cache, 1 = D-cache; valid while busy.
- busy  out  1  high while a transaction is outstanding.

Behaviour:
- States: IDLE, SERVE.
- IDLE to SERVE when ic_mem_read or (dc_mem_read or dc_mem_write) is high.
  - Winner chosen, then latched at the same edge: addr, rw, wdata, grant_id.
  - Requests are sampled only in IDLE.
- Arbitration: round-robin on a last_grant flop (reset 1, so the I-cache wins the first tie).
  - Single requester always wins.
  - On tie, the port not granted last wins.
  - last_grant updates at the grant edge.
- D-cache with dc_mem_read and dc_mem_write both high: treated as write.
- SERVE:
  - mem_read = latched_read & ~mem_ready; mem_write = latched_write & ~mem_ready.
  - mem_addr/mem_wdata driven from latched registers, so they are stable for the whole transaction.
  - On mem_ready: the granted port's *_mem_ready = 1 in the same cycle (combinational pass-through); next state is IDLE.
- Latency:
  - Request seen at edge N; mem strobe high from cycle N+1.
  - Ready returned the same cycle as mem_ready.
  - Minimum gap between two memory transactions: 1 IDLE cycle.
- Read data: ic_mem_rdata = dc_mem_rdata = mem_rdata at all times (broadcast). Only ready is gated.
- Non-granted port ready = 0 always. Waiting cache simply keeps its request asserted.
- mem_ready while IDLE: ignored; no ready forwarded, no state change.
- Requester withdrawing a request during SERVE: ignored (protocol violation); the latched transaction completes.
- D-cache writeback followed immediately by allocate: re-arbitrated in IDLE like any new request. The I-cache wins if it was pending, per round-robin.
- Reset (proc_reset_n = 0 at edge):
  - State IDLE, last_grant = 1.
  - mem_read = mem_write = 0; mem_addr, mem_wdata, grant_id, busy = 0; both *_mem_ready = 0.
  - An in-flight transaction is abandoned with no ready returned.
  - Reset overrides a simultaneous mem_ready.
- busy = (state == SERVE).

Optional Feature:
- Macro MEM_ARB_DCACHE_PRIORITY_EN.
- Defined: fixed priority; the D-cache always wins a tie. last_grant is not used.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
- Single I-cache read:
  - Stimulus: ic_mem_read = 1, addr 0x0000010; memory returns ready 3 cycles after its strobe with rdata 0xAAAA..., as described in the Behaviour section.
  - Required response: mem_read=1, mem_addr=0x0000010 for 3 cycles, then ic_mem_ready=1 with ic_mem_rdata=0xAAAA..., then IDLE.
- Simultaneous I read 0x10 and D read 0x20 from reset:
  - Required response: I served first (grant_id=0). D served next (grant_id=1, mem_addr=0x20) after one IDLE cycle. dc_mem_ready is never high during the I transaction.
- D writeback then allocate, with I pending:
  - Stimulus: D write addr 0x30 with wdata 0x1234..., then D read 0x40; I read 0x50 held throughout.
  - Required response: order is D-write 0x30, I-read 0x50, D-read 0x40; mem_wdata=0x1234... during the write.
- Reset mid-SERVE:
  - Stimulus: pull proc_reset_n low 2 cycles into a D write.
  - Required response: next cycle mem_write=0, busy=0, no dc_mem_ready. After release, a held request is re-served from scratch.
- Spurious mem_ready in IDLE with no requests:
  - Required response: ic_mem_ready=dc_mem_ready=0, state stays IDLE.
- MEM_ARB_DCACHE_PRIORITY_EN build:
  - Stimulus: repeated simultaneous I/D requests.
  - Required response: D wins every tie; I is served only when D is idle.
